// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous input
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-N-1 UART receiver sampling mid-bit on an oversampling clock
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int             CW    = $clog2(OVERSAMPLE);
  localparam int             BW    = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0]  H_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  OS_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  LAST  = BW'(UART_DATA_BITS - 1);

  logic rxs;

  sync2 #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  uart_state_e               state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;

  logic line_low;
  assign line_low = (rxs != UART_IDLE_LEVEL);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (line_low) state_d = START;
      START:     if (cnt_q == H_M1) state_d = line_low ? DATA : IDLE;
      DATA:      if (cnt_q == OS_M1 && bit_q == LAST) state_d = STOP;
      STOP:      if (cnt_q == OS_M1) state_d = line_low ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (!line_low) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath updates; strobes default low so each fires for a single cycle.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: cnt_d = '0;
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == H_M1 && line_low) begin
          cnt_d = '0;
          bit_d = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == OS_M1) begin
          shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = '0;
          bit_d   = bit_q + BW'(1);
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == OS_M1) begin
          if (line_low) begin
            ferr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at OVERSAMPLE=16
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       lb_mode = 1'b0;
  logic       rx_pin;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  logic [3:0] div = 4'd0;
  logic       tx_clk;
  logic       tx_line = 1'b1;
  logic       tx_busy = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_req_data = 8'h00;
  logic [9:0] tx_sh = 10'h3ff;
  int         tx_n = 0;

  assign rx_pin = lb_mode ? tx_line : rx_drv;
  assign tx_clk = div[3];

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_pin),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference transmitter for loopback, clocked at clk/16.
  always @(posedge clk) div <= div + 4'd1;

  always @(posedge tx_clk) begin
    if (!tx_busy) begin
      if (tx_req) begin
        tx_sh   <= {1'b1, tx_req_data, 1'b0};
        tx_n    <= 0;
        tx_busy <= 1'b1;
      end
    end else begin
      tx_line <= tx_sh[0];
      tx_sh   <= {1'b1, tx_sh[9:1]};
      if (tx_n == 9) tx_busy <= 1'b0;
      else           tx_n <= tx_n + 1;
    end
  end

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_strobe = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (valid || frame_err) begin
        n_checks++;
        if (valid && frame_err) begin
          n_fail++;
          $display("FAIL strobe_exclusive: valid=%b frame_err=%b at cyc %0d, required not both", valid, frame_err, cyc);
        end
        n_checks++;
        if (prev_strobe) begin
          n_fail++;
          $display("FAIL strobe_width: strobe still high at cyc %0d, required one cycle", cyc);
        end
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: valid=%b frame_err=%b data=%h at cyc %0d, required none", valid, frame_err, data, cyc);
        end else begin
          mon_e = sb.pop_front();
          n_checks++;
          if (frame_err !== mon_e.err) begin
            n_fail++;
            $display("FAIL strobe_kind: frame_err=%b, required %b", frame_err, mon_e.err);
          end
          n_checks++;
          if (data !== mon_e.data) begin
            n_fail++;
            $display("FAIL data: got %h, required %h", data, mon_e.data);
          end
          if (mon_e.cyc >= 0) begin
            n_checks++;
            if (cyc != mon_e.cyc) begin
              n_fail++;
              $display("FAIL latency: strobe at cyc %0d, required %0d", cyc, mon_e.cyc);
            end
          end
        end
      end
      prev_strobe = valid || frame_err;
    end
  end

  task automatic expect_strobe(input logic err, input logic [7:0] d, input int at);
    exp_t e;
    e.err  = err;
    e.data = d;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic drive_bits(input logic b, input int n);
    rx_drv = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    drive_bits(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bits(b[i], 16);
    drive_bits(stop_bit, stop_len);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d strobes outstanding, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, required 00", data); end
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    drive_bits(1'b1, 8);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single;
    expect_strobe(1'b0, 8'hA5, cyc + 155);
    send_frame(8'hA5, 1'b1, 16);
    drive_bits(1'b1, 20);
    wait_drain("single");
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, required 0", busy); end
    n_checks++;
    if (data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h, required a5", data); end
  endtask

  task automatic test_back_to_back;
    expect_strobe(1'b0, 8'h00, cyc + 155);
    expect_strobe(1'b0, 8'hFF, cyc + 155 + 160);
    send_frame(8'h00, 1'b1, 16);
    send_frame(8'hFF, 1'b1, 16);
    drive_bits(1'b1, 20);
    wait_drain("back_to_back");
  endtask

  task automatic test_glitch;
    logic saw_busy;
    saw_busy = 1'b0;
    drive_bits(1'b0, 4);
    rx_drv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy) saw_busy = 1'b1;
    end
    n_checks++;
    if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_pulse: saw %b, required 1", saw_busy); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy %b, required 0", busy); end
    expect_strobe(1'b0, 8'h3C, cyc + 155);
    send_frame(8'h3C, 1'b1, 16);
    drive_bits(1'b1, 20);
    wait_drain("glitch");
  endtask

  task automatic test_frame_err;
    expect_strobe(1'b0, 8'h5A, cyc + 155);
    send_frame(8'h5A, 1'b1, 16);
    expect_strobe(1'b1, 8'h5A, cyc + 155);
    send_frame(8'h77, 1'b0, 40);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b, required 1", busy); end
    drive_bits(1'b1, 5);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release: busy %b, required 0", busy); end
    n_checks++;
    if (data !== 8'h5A) begin n_fail++; $display("FAIL ferr_data_hold: got %h, required 5a", data); end
    wait_drain("frame_err");
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'h96;
    drive_bits(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bits(b[i], 16);
    rst = 1'b1;
    rx_drv = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    n_checks++;
    if (data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h, required 00", data); end
    drive_bits(1'b1, 200);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet: busy %b, required 0", busy); end
    expect_strobe(1'b0, 8'hC3, cyc + 155);
    send_frame(8'hC3, 1'b1, 16);
    drive_bits(1'b1, 20);
    wait_drain("reset_mid");
  endtask

  task automatic tx_send(input logic [7:0] b);
    int n;
    tx_req_data = b;
    tx_req = 1'b1;
    n = 0;
    while (!tx_busy && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    tx_req = 1'b0;
    n_checks++;
    if (!tx_busy) begin n_fail++; $display("FAIL loopback_load: tx_busy %b, required 1", tx_busy); end
    n = 0;
    while (tx_busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (tx_busy) begin n_fail++; $display("FAIL loopback_tx_done: tx_busy %b, required 0", tx_busy); end
  endtask

  task automatic test_loopback;
    logic [7:0] bytes [4];
    bytes[0] = 8'h01;
    bytes[1] = 8'h80;
    bytes[2] = 8'hFF;
    bytes[3] = 8'h00;
    lb_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_strobe(1'b0, bytes[i], -1);
      tx_send(bytes[i]);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    wait_drain("loopback");
    lb_mode = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
